// File: rtl/zet_bus_pkg.sv
// Shared types and constants for the zet Wishbone bus master.
// Optional access timeout is enabled with `define ZET_BUS_TIMEOUT_EN.
package zet_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CYC1 = 2'd1,
      ST_CYC2 = 2'd2,
      ST_DONE = 2'd3
   } bus_state_e;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

   // Word address of the upper half of an odd-address word. Memory wraps at
   // 1M; I/O space is 64K, so it wraps at 16 bits and the top bits stay 0.
   function automatic logic [18:0] next_word_adr(input logic [18:0] wadr,
                                                  input logic        io);
      logic [18:0] r;
      if (io) r = {4'b0000, wadr[14:0] + 15'd1};
      else    r = wadr + 19'd1;
      return r;
   endfunction

endpackage

// File: rtl/zet_bus_lane.sv
// Byte-lane steering: select generation, write-data replication and
// merging of the returned lane into the read-data register.
module zet_bus_lane (
   input  logic        byteop_i,
   input  logic        a0_i,
   input  logic        second_i,
   input  logic [15:0] wr_data_i,
   input  logic [15:0] rd_data_i,
   input  logic [15:0] mem_i,
   output logic [1:0]  sel_o,
   output logic [15:0] dat_o,
   output logic [15:0] mem_o
);

   logic       word_aligned;
   logic [7:0] rd_byte;

   always_comb begin
      word_aligned = ~byteop_i & ~a0_i;

      // Odd word: first half rides the upper lane, second half the lower one.
      if (word_aligned)           sel_o = 2'b11;
      else if (second_i | ~a0_i)  sel_o = 2'b01;
      else                        sel_o = 2'b10;

      if (word_aligned)  dat_o = wr_data_i;
      else if (second_i) dat_o = {2{wr_data_i[15:8]}};
      else               dat_o = {2{wr_data_i[7:0]}};

      rd_byte = sel_o[1] ? rd_data_i[15:8] : rd_data_i[7:0];

      if (word_aligned)  mem_o = rd_data_i;
      else if (byteop_i) mem_o = {8'h00, rd_byte};
      else if (second_i) mem_o = {rd_byte, mem_i[7:0]};
      else               mem_o = {mem_i[15:8], rd_byte};
   end

endmodule

// File: rtl/zet_bus_master.sv
// Exec-side to Wishbone bridge: word, byte and split odd-word accesses.
// `define ZET_BUS_TIMEOUT_EN adds a 255-cycle ack timeout with bus_err.
module zet_bus_master
   import zet_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [19:0] addr,
   input  logic [15:0] wr_data,
   input  logic        we,
   input  logic        m_io,
   input  logic        byteop,
   output logic [15:0] memout,
   output logic        block,
   output logic        bus_err,
   output logic [18:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   output logic [1:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_tga_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [15:0] wb_dat_i,
   input  logic        wb_ack_i
);

   bus_state_e  state_q;
   logic [19:0] addr_q;
   logic [15:0] wr_data_q;
   logic        we_q, m_io_q, byteop_q;
   logic        cyc_q, gap_q, bus_err_q;
   logic [15:0] memout_q;

   logic        second, ack_act, tmo_hit;
   logic [1:0]  lane_sel;
   logic [15:0] lane_dat, lane_mem;

   assign second  = (state_q == ST_CYC2);
   assign ack_act = cyc_q & wb_ack_i;

`ifdef ZET_BUS_TIMEOUT_EN
   logic [7:0] tmo_q;
   assign tmo_hit = cyc_q & ~wb_ack_i & (tmo_q == TIMEOUT_LIMIT - 8'd1);
`else
   assign tmo_hit = 1'b0;
`endif

   zet_bus_lane u_lane (
      .byteop_i  (byteop_q),
      .a0_i      (addr_q[0]),
      .second_i  (second),
      .wr_data_i (wr_data_q),
      .rd_data_i (wb_dat_i),
      .mem_i     (memout_q),
      .sel_o     (lane_sel),
      .dat_o     (lane_dat),
      .mem_o     (lane_mem)
   );

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = cyc_q & we_q;
   assign wb_sel_o = cyc_q ? lane_sel : 2'b00;
   assign wb_adr_o = second ? next_word_adr(addr_q[19:1], m_io_q) : addr_q[19:1];
   assign wb_dat_o = lane_dat;
   assign wb_tga_o = m_io_q;
   assign memout   = memout_q;
   assign bus_err  = bus_err_q;
   assign block    = cpu_req & (state_q != ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         we_q      <= 1'b0;
         m_io_q    <= 1'b0;
         byteop_q  <= 1'b0;
         cyc_q     <= 1'b0;
         gap_q     <= 1'b0;
         memout_q  <= '0;
         bus_err_q <= 1'b0;
`ifdef ZET_BUS_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         bus_err_q <= 1'b0;
`ifdef ZET_BUS_TIMEOUT_EN
         tmo_q <= cyc_q ? tmo_q + 8'd1 : 8'd0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (cpu_req) begin
                  addr_q    <= addr;
                  wr_data_q <= wr_data;
                  we_q      <= we;
                  m_io_q    <= m_io;
                  byteop_q  <= byteop;
                  cyc_q     <= 1'b1;
                  state_q   <= ST_CYC1;
               end
            end
            ST_CYC1: begin
               if (ack_act) begin
                  if (!we_q) memout_q <= lane_mem;
                  cyc_q <= 1'b0;
                  if (addr_q[0] & ~byteop_q) begin
                     gap_q   <= 1'b1;
                     state_q <= ST_CYC2;
                  end else begin
                     state_q <= ST_DONE;
                  end
               end else if (tmo_hit) begin
                  cyc_q     <= 1'b0;
                  memout_q  <= 16'hFFFF;
                  bus_err_q <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            ST_CYC2: begin
               // First clock of CYC2 keeps the bus idle between the halves.
               if (gap_q) begin
                  gap_q <= 1'b0;
                  cyc_q <= 1'b1;
               end else if (ack_act) begin
                  if (!we_q) memout_q <= lane_mem;
                  cyc_q   <= 1'b0;
                  state_q <= ST_DONE;
               end else if (tmo_hit) begin
                  cyc_q     <= 1'b0;
                  memout_q  <= 16'hFFFF;
                  bus_err_q <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zet_bus_master.sv
// Directed bench for zet_bus_master with a scoreboarded Wishbone slave.
module tb_zet_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [19:0] addr;
   logic [15:0] wr_data;
   logic        we, m_io, byteop;
   logic [15:0] memout;
   logic        block, bus_err;
   logic [18:0] wb_adr_o;
   logic [15:0] wb_dat_o;
   logic [1:0]  wb_sel_o;
   logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o;
   logic [15:0] wb_dat_i;
   logic        wb_ack_i;

   typedef struct {
      logic [18:0] adr;
      logic [1:0]  sel;
      logic        we;
      logic        tga;
      logic [15:0] wdat;
      logic [15:0] wmask;
      logic [15:0] rdat;
      int          ws;
      int          gap;
      bit          no_ack;
   } cyc_t;

   cyc_t        exp_q[$];
   logic [15:0] mem_q[$];
   cyc_t        cur;
   int          total = 0;
   int          bad = 0;
   int          cyc_cnt = 0;
   int          fall_at = 0;
   int          wcnt = 0;
   bit          busy = 0;
   bit          prev_cyc = 0;
   bit          inject_ack = 0;

   zet_bus_master dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .addr(addr), .wr_data(wr_data),
      .we(we), .m_io(m_io), .byteop(byteop), .memout(memout), .block(block),
      .bus_err(bus_err), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push_cyc(input logic [18:0] adr, input logic [1:0] sel,
                           input logic w, input logic io, input logic [15:0] wdat,
                           input logic [15:0] wmask, input logic [15:0] rdat,
                           input int ws, input int gap, input bit no_ack);
      cyc_t c;
      c.adr = adr; c.sel = sel; c.we = w; c.tga = io; c.wdat = wdat;
      c.wmask = wmask; c.rdat = rdat; c.ws = ws; c.gap = gap; c.no_ack = no_ack;
      exp_q.push_back(c);
   endtask

   // Wishbone slave: checks each strobe against the scoreboard and acks it.
   initial begin
      wb_ack_i = 1'b0;
      wb_dat_i = 16'h0000;
      cur.no_ack = 1'b0;
      cur.ws = 0;
      forever begin
         @(negedge clk);
         cyc_cnt++;
         if (prev_cyc && !wb_cyc_o) fall_at = cyc_cnt;
         prev_cyc = wb_cyc_o;
         if (wb_ack_i) begin
            wb_ack_i = 1'b0;
         end else if (wb_cyc_o && wb_stb_o) begin
            if (!busy) begin
               busy = 1;
               wcnt = 0;
               check("cyc_expected", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  check("wb_adr", wb_adr_o, cur.adr);
                  check("wb_sel", wb_sel_o, cur.sel);
                  check("wb_we", wb_we_o, cur.we);
                  check("wb_tga", wb_tga_o, cur.tga);
                  if (cur.wmask != 16'h0) check("wb_dat", wb_dat_o & cur.wmask, cur.wdat & cur.wmask);
                  if (cur.gap >= 0) check("idle_gap", cyc_cnt - fall_at, cur.gap);
               end
            end
            if (!cur.no_ack && wcnt >= cur.ws) begin
               wb_dat_i = cur.rdat;
               wb_ack_i = 1'b1;
               busy = 0;
            end else begin
               wcnt++;
            end
         end else begin
            busy = 0;
            if (inject_ack) begin
               wb_dat_i = 16'hFFFF;
               wb_ack_i = 1'b1;
            end
         end
      end
   end

   task automatic do_access(input logic [19:0] a, input logic [15:0] wd, input logic w,
                            input logic io, input logic bo, input int exp_n,
                            input bit scr, input logic exp_err);
      int n;
      bit done;
      logic [15:0] em;
      @(negedge clk);
      addr = a; wr_data = wd; we = w; m_io = io; byteop = bo; cpu_req = 1'b1;
      n = 0;
      done = 0;
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
         if (scr && n == 1) begin
            addr = ~a; wr_data = ~wd; we = ~w; m_io = ~io; byteop = ~bo;
         end
         if (!block) done = 1;
      end
      check("done_reached", done, 1'b1);
      check("latency", n, exp_n);
      em = mem_q.pop_front();
      check("memout", memout, em);
      check("bus_err", bus_err, exp_err);
      cpu_req = 1'b0;
      check("pending_cycles", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; cpu_req = 1'b0; addr = '0; wr_data = '0;
      we = 1'b0; m_io = 1'b0; byteop = 1'b0;
      #2;
      check("rst_cyc", wb_cyc_o, 1'b0);
      check("rst_stb", wb_stb_o, 1'b0);
      check("rst_we", wb_we_o, 1'b0);
      check("rst_sel", wb_sel_o, 2'b00);
      check("rst_adr", wb_adr_o, 19'h0);
      check("rst_dat", wb_dat_o, 16'h0);
      check("rst_memout", memout, 16'h0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_block", block, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // aligned word read, 2 wait states
      push_cyc(19'h091A, 2'b11, 0, 0, 16'h0, 16'h0, 16'hBEEF, 2, -1, 0);
      mem_q.push_back(16'hBEEF);
      do_access(20'h01234, 16'h0, 0, 0, 0, 4, 0, 0);

      // odd word write, split across two cycles with one idle clock
      push_cyc(19'h00080, 2'b10, 1, 0, 16'h5A00, 16'hFF00, 16'h0, 0, -1, 0);
      push_cyc(19'h00081, 2'b01, 1, 0, 16'h00A5, 16'h00FF, 16'h0, 0, 1, 0);
      mem_q.push_back(16'hBEEF);
      do_access(20'h00101, 16'hA55A, 1, 0, 0, 4, 0, 0);

      // I/O byte read from the upper lane
      push_cyc(19'h07FFF, 2'b10, 0, 1, 16'h0, 16'h0, 16'h7700, 1, -1, 0);
      mem_q.push_back(16'h0077);
      do_access(20'h0FFFF, 16'h0, 0, 1, 1, 3, 0, 0);

      // odd word read at top of memory wraps; inputs scrambled mid-access
      push_cyc(19'h7FFFF, 2'b10, 0, 0, 16'h0, 16'h0, 16'h3412, 1, -1, 0);
      push_cyc(19'h00000, 2'b01, 0, 0, 16'h0, 16'h0, 16'hCD56, 0, 1, 0);
      mem_q.push_back(16'h5634);
      do_access(20'hFFFFF, 16'h0, 0, 0, 0, 5, 1, 0);

      // odd word I/O read wraps at 64K
      push_cyc(19'h07FFF, 2'b10, 0, 1, 16'h0, 16'h0, 16'h1100, 0, -1, 0);
      push_cyc(19'h00000, 2'b01, 0, 1, 16'h0, 16'h0, 16'h0022, 0, 1, 0);
      mem_q.push_back(16'h2211);
      do_access(20'h0FFFF, 16'h0, 0, 1, 0, 4, 0, 0);

      // byte write at odd address replicates on both lanes
      push_cyc(19'h00102, 2'b10, 1, 0, 16'hC3C3, 16'hFFFF, 16'h0, 0, -1, 0);
      mem_q.push_back(16'h2211);
      do_access(20'h00205, 16'h00C3, 1, 0, 1, 2, 0, 0);

      // aligned word write, 3 wait states
      push_cyc(19'h00200, 2'b11, 1, 0, 16'h1234, 16'hFFFF, 16'h0, 3, -1, 0);
      mem_q.push_back(16'h2211);
      do_access(20'h00400, 16'h1234, 1, 0, 0, 5, 0, 0);

      // byte read from even address uses the lower lane
      push_cyc(19'h00008, 2'b01, 0, 0, 16'h0, 16'h0, 16'hAB99, 0, -1, 0);
      mem_q.push_back(16'h0099);
      do_access(20'h00010, 16'h0, 0, 0, 1, 2, 0, 0);

      // stray acks while idle must not disturb anything
      @(negedge clk);
      inject_ack = 1;
      repeat (4) @(negedge clk);
      inject_ack = 0;
      repeat (2) @(negedge clk);
      check("stray_ack_memout", memout, 16'h0099);
      check("stray_ack_cyc", wb_cyc_o, 1'b0);

      // reset while the second half of an odd word is on the bus
      push_cyc(19'h00180, 2'b10, 0, 0, 16'h0, 16'h0, 16'h5500, 0, -1, 0);
      push_cyc(19'h00181, 2'b01, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1);
      @(negedge clk);
      addr = 20'h00301; we = 0; m_io = 0; byteop = 0; cpu_req = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_cyc", wb_cyc_o, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("midrst_cyc", wb_cyc_o, 1'b0);
      check("midrst_stb", wb_stb_o, 1'b0);
      check("midrst_sel", wb_sel_o, 2'b00);
      check("midrst_adr", wb_adr_o, 19'h0);
      check("midrst_memout", memout, 16'h0);
      check("midrst_block", block, 1'b1);
      check("midrst_pending", exp_q.size(), 0);
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      push_cyc(19'h00180, 2'b10, 0, 0, 16'h0, 16'h0, 16'h6600, 0, -1, 0);
      push_cyc(19'h00181, 2'b01, 0, 0, 16'h0, 16'h0, 16'h0077, 0, 1, 0);
      mem_q.push_back(16'h7766);
      do_access(20'h00301, 16'h0, 0, 0, 0, 4, 0, 0);

`ifdef ZET_BUS_TIMEOUT_EN
      // no ack: abort after 255 strobe cycles
      push_cyc(19'h00080, 2'b11, 0, 0, 16'h0, 16'h0, 16'h0, 0, -1, 1);
      mem_q.push_back(16'hFFFF);
      do_access(20'h00100, 16'h0, 0, 0, 0, 256, 0, 1);
      @(negedge clk);
      check("tmo_err_pulse_end", bus_err, 1'b0);
      check("tmo_cyc_idle", wb_cyc_o, 1'b0);
`else
      @(negedge clk);
      check("no_tmo_bus_err", bus_err, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
